// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register-file constants, FSM states and requester indices
package rf_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int REG_COUNT  = 32;
  localparam int ZERO_REG   = 0;

  typedef enum logic {
    ST_SERVE,
    ST_CLEAR
  } wb_state_e;

  localparam int REQ_ALU = 0;
  localparam int REQ_MEM = 1;
endpackage

// File: rtl/rf_wb_arbiter_rr_arb2.sv
// rtl/rf_wb_arbiter_rr_arb2.sv - two-way round-robin grant with pointer register
module rr_arb2
  import rf_pkg::*;
#(
  parameter int PRIO_INIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       force_off,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic rr;

  always_comb begin
    gnt = 2'b00;
    if (en && !force_off) begin
      if (req == 2'b11) gnt = rr ? 2'b10 : 2'b01;
      else              gnt = req;
    end
  end

  // Pointer moves to the loser after every grant, even with a lone requester.
  always_ff @(posedge clk) begin
    if (rst)                  rr <= 1'(PRIO_INIT);
    else if (gnt[REQ_ALU])    rr <= 1'(REQ_MEM);
    else if (gnt[REQ_MEM])    rr <= 1'(REQ_ALU);
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register-file write port arbiter with r1..r31 clear sequencer
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int ADDR_W    = REG_ADDR_W,
  parameter int DATA_W    = REG_DATA_W,
  parameter int NUM_REGS  = REG_COUNT,
  parameter int PRIO_INIT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              clr_req,
  output logic              busy_o,
  output logic              clr_done_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  wb_state_e         state, state_d;
  logic [ADDR_W-1:0] cnt, cnt_d;
  logic              wr_en_d, clr_done_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [DATA_W-1:0] wr_data_d;
  logic [1:0]        gnt;

  rr_arb2 #(.PRIO_INIT(PRIO_INIT)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .en        (state == ST_SERVE),
    .force_off (clr_req | rst),
    .req       ({mem_valid, alu_valid}),
    .gnt       (gnt)
  );

  assign alu_ready = gnt[REQ_ALU];
  assign mem_ready = gnt[REQ_MEM];
  assign busy_o    = (state == ST_CLEAR) | clr_done_o;

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_o;
    wr_data_d  = wr_data_o;
    clr_done_d = 1'b0;
    case (state)
      ST_SERVE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = ADDR_W'(1);
        end else if (gnt[REQ_ALU]) begin
          // r0 writes complete the handshake but never reach the file
          wr_en_d   = (alu_addr != ZERO_ADDR);
          wr_addr_d = alu_addr;
          wr_data_d = alu_data;
        end else if (gnt[REQ_MEM]) begin
          wr_en_d   = (mem_addr != ZERO_ADDR);
          wr_addr_d = mem_addr;
          wr_data_d = mem_data;
        end
      end
      ST_CLEAR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = cnt;
        wr_data_d = '0;
        cnt_d     = cnt + ADDR_W'(1);
        if (cnt == LAST_ADDR) begin
          clr_done_d = 1'b1;
          state_d    = ST_SERVE;
          cnt_d      = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_SERVE;
      cnt        <= '0;
      wr_en_o    <= 1'b0;
      wr_addr_o  <= '0;
      wr_data_o  <= '0;
      clr_done_o <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      wr_en_o    <= wr_en_d;
      wr_addr_o  <= wr_addr_d;
      wr_data_o  <= wr_data_d;
      clr_done_o <= clr_done_d;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mem_valid, clr_req;
  logic [4:0]  alu_addr, mem_addr;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready, busy_o, clr_done_o, wr_en_o;
  logic [4:0]  wr_addr_o;
  logic [31:0] wr_data_o;

  int checks = 0;
  int errors = 0;

  rf_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .clr_req(clr_req), .busy_o(busy_o), .clr_done_o(clr_done_o),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; alu_valid = 1'b0; mem_valid = 1'b0; clr_req = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; alu_valid = 1'b0; mem_valid = 1'b0; clr_req = 1'b0;
    alu_addr = '0; mem_addr = '0; alu_data = '0; mem_data = '0;
    step(); step();
    rst = 1'b0;
    checks++; if (wr_en_o !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %0b exp 0", wr_en_o); end
    checks++; if (wr_addr_o !== 5'd0) begin errors++; $display("FAIL reset_wr_addr got %0d exp 0", wr_addr_o); end
    checks++; if (wr_data_o !== 32'd0) begin errors++; $display("FAIL reset_wr_data got %h exp 0", wr_data_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy_o); end
    checks++; if (clr_done_o !== 1'b0) begin errors++; $display("FAIL reset_clr_done got %0b exp 0", clr_done_o); end
  endtask

  task automatic test_single();
    do_reset();
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %0b exp 1", alu_ready); end
    step();
    alu_valid = 1'b0;
    checks++; if (wr_en_o !== 1'b1) begin errors++; $display("FAIL single_wr_en got %0b exp 1", wr_en_o); end
    checks++; if (wr_addr_o !== 5'd5) begin errors++; $display("FAIL single_wr_addr got %0d exp 5", wr_addr_o); end
    checks++; if (wr_data_o !== 32'hDEADBEEF) begin errors++; $display("FAIL single_wr_data got %h exp deadbeef", wr_data_o); end
    step();
    checks++; if (wr_en_o !== 1'b0) begin errors++; $display("FAIL single_wr_en_after got %0b exp 0", wr_en_o); end
  endtask

  task automatic test_alternate();
    logic       exp_a;
    logic [4:0] exp_addr;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h11;
      mem_valid = 1'b1; mem_addr = 5'd2; mem_data = 32'h22;
      exp_a = (i % 2 == 0);
      #1;
      checks++; if (alu_ready !== exp_a) begin errors++; $display("FAIL alt_alu_ready[%0d] got %0b exp %0b", i, alu_ready, exp_a); end
      checks++; if (mem_ready !== !exp_a) begin errors++; $display("FAIL alt_mem_ready[%0d] got %0b exp %0b", i, mem_ready, !exp_a); end
      step();
      exp_addr = exp_a ? 5'd1 : 5'd2;
      checks++; if (wr_en_o !== 1'b1 || wr_addr_o !== exp_addr) begin
        errors++; $display("FAIL alt_write[%0d] got en %0b addr %0d exp en 1 addr %0d", i, wr_en_o, wr_addr_o, exp_addr);
      end
      checks++; if (wr_data_o !== (exp_a ? 32'h11 : 32'h22)) begin
        errors++; $display("FAIL alt_data[%0d] got %h exp %h", i, wr_data_o, exp_a ? 32'h11 : 32'h22);
      end
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
  endtask

  task automatic test_r0();
    alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'hFFFFFFFF;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL r0_ready got %0b exp 1", alu_ready); end
    step();
    alu_valid = 1'b0;
    checks++; if (wr_en_o !== 1'b0) begin errors++; $display("FAIL r0_wr_en got %0b exp 0", wr_en_o); end
  endtask

  task automatic test_clear(input bit from_mem);
    logic [4:0]  req_addr;
    logic [31:0] req_data;
    logic        rdy, exp_en;
    req_addr = from_mem ? 5'd7 : 5'd9;
    req_data = from_mem ? 32'hA5A5A5A5 : 32'h5A5A5A5A;
    clr_req = 1'b1;
    if (from_mem) begin mem_valid = 1'b1; mem_addr = req_addr; mem_data = req_data; end
    else          begin alu_valid = 1'b1; alu_addr = req_addr; alu_data = req_data; end
    #1;
    rdy = from_mem ? mem_ready : alu_ready;
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL clr%0d_ready_T got %0b exp 0", from_mem, rdy); end
    step();
    clr_req = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      exp_en = (k >= 2);
      checks++; if (busy_o !== (k <= 32)) begin errors++; $display("FAIL clr%0d_busy[T+%0d] got %0b exp %0b", from_mem, k, busy_o, k <= 32); end
      checks++; if (clr_done_o !== (k == 32)) begin errors++; $display("FAIL clr%0d_done[T+%0d] got %0b exp %0b", from_mem, k, clr_done_o, k == 32); end
      checks++; if (wr_en_o !== exp_en) begin errors++; $display("FAIL clr%0d_wr_en[T+%0d] got %0b exp %0b", from_mem, k, wr_en_o, exp_en); end
      if (k >= 2 && k <= 32) begin
        checks++; if (wr_addr_o !== 5'(k - 1) || wr_data_o !== 32'd0) begin
          errors++; $display("FAIL clr%0d_wr[T+%0d] got addr %0d data %h exp addr %0d data 0", from_mem, k, wr_addr_o, wr_data_o, k - 1);
        end
      end
      if (k == 33) begin
        alu_valid = 1'b0; mem_valid = 1'b0;
        checks++; if (wr_addr_o !== req_addr || wr_data_o !== req_data) begin
          errors++; $display("FAIL clr%0d_req_write got addr %0d data %h exp addr %0d data %h", from_mem, wr_addr_o, wr_data_o, req_addr, req_data);
        end
      end
      #1;
      rdy = from_mem ? mem_ready : alu_ready;
      checks++; if (rdy !== (k == 32)) begin errors++; $display("FAIL clr%0d_ready[T+%0d] got %0b exp %0b", from_mem, k, rdy, k == 32); end
      step();
    end
  endtask

  task automatic test_reset_mid_clear();
    int pulses;
    int stray;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int k = 1; k <= 10; k++) step();
    checks++; if (wr_en_o !== 1'b1 || wr_addr_o !== 5'd10) begin
      errors++; $display("FAIL midclr_pre got en %0b addr %0d exp en 1 addr 10", wr_en_o, wr_addr_o);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (wr_en_o !== 1'b0) begin errors++; $display("FAIL midclr_wr_en got %0b exp 0", wr_en_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL midclr_busy got %0b exp 0", busy_o); end
    pulses = (clr_done_o === 1'b1) ? 1 : 0;
    stray = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (clr_done_o !== 1'b0) pulses++;
      if (wr_en_o !== 1'b0 || busy_o !== 1'b0) stray++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL midclr_done_pulses got %0d exp 0", pulses); end
    checks++; if (stray !== 0) begin errors++; $display("FAIL midclr_stray_activity got %0d exp 0", stray); end
    alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h33;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL midclr_req_ready got %0b exp 1", alu_ready); end
    step();
    alu_valid = 1'b0;
    checks++; if (wr_en_o !== 1'b1 || wr_addr_o !== 5'd3 || wr_data_o !== 32'h33) begin
      errors++; $display("FAIL midclr_req_write got en %0b addr %0d data %h exp en 1 addr 3 data 33", wr_en_o, wr_addr_o, wr_data_o);
    end
  endtask

  // Cycle-level model: pending requests per requester, a priority bit and a clear countdown.
  task automatic test_random();
    bit          pend_a = 0, pend_m = 0, next_a = 0, clr = 0;
    logic [4:0]  a_addr = '0, m_addr = '0, exp_addr = '0, n_addr;
    logic [31:0] a_data = '0, m_data = '0, exp_data = '0, n_data;
    bit          exp_en = 0, exp_done = 0, n_en, n_done, g_a, g_m;
    int          clr_left = 0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      checks++; if (wr_en_o !== exp_en) begin errors++; $display("FAIL rnd_wr_en[%0d] got %0b exp %0b", c, wr_en_o, exp_en); end
      if (exp_en) begin
        checks++; if (wr_addr_o !== exp_addr || wr_data_o !== exp_data) begin
          errors++; $display("FAIL rnd_wr[%0d] got addr %0d data %h exp addr %0d data %h", c, wr_addr_o, wr_data_o, exp_addr, exp_data);
        end
      end
      checks++; if (clr_done_o !== exp_done) begin errors++; $display("FAIL rnd_done[%0d] got %0b exp %0b", c, clr_done_o, exp_done); end
      checks++; if (busy_o !== (clr_left > 0 || exp_done)) begin errors++; $display("FAIL rnd_busy[%0d] got %0b exp %0b", c, busy_o, clr_left > 0 || exp_done); end

      if (!pend_a && ($urandom % 3 != 0)) begin pend_a = 1; a_addr = 5'($urandom % 32); a_data = $urandom; end
      if (!pend_m && ($urandom % 3 != 0)) begin pend_m = 1; m_addr = 5'($urandom % 32); m_data = $urandom; end
      clr = ($urandom % 60 == 0);
      alu_valid = pend_a; alu_addr = a_addr; alu_data = a_data;
      mem_valid = pend_m; mem_addr = m_addr; mem_data = m_data;
      clr_req = clr;

      g_a = 0; g_m = 0; n_en = 0; n_done = 0; n_addr = exp_addr; n_data = exp_data;
      if (clr_left > 0) begin
        n_en = 1; n_addr = 5'(32 - clr_left); n_data = '0; n_done = (clr_left == 1);
        clr_left--;
      end else if (clr) begin
        clr_left = 31;
      end else begin
        if (pend_a && pend_m) begin g_a = !next_a ? 1'b1 : 1'b0; g_m = !g_a; end
        else begin g_a = pend_a; g_m = pend_m; end
        if (g_a) begin n_en = (a_addr != 0); n_addr = a_addr; n_data = a_data; pend_a = 0; next_a = 1; end
        else if (g_m) begin n_en = (m_addr != 0); n_addr = m_addr; n_data = m_data; pend_m = 0; next_a = 0; end
      end
      #1;
      checks++; if (alu_ready !== g_a) begin errors++; $display("FAIL rnd_alu_ready[%0d] got %0b exp %0b", c, alu_ready, g_a); end
      checks++; if (mem_ready !== g_m) begin errors++; $display("FAIL rnd_mem_ready[%0d] got %0b exp %0b", c, mem_ready, g_m); end
      exp_en = n_en; exp_addr = n_addr; exp_data = n_data; exp_done = n_done;
      step();
    end
    alu_valid = 1'b0; mem_valid = 1'b0; clr_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_r0();
    test_clear(1'b1);
    test_clear(1'b0);
    test_reset_mid_clear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
